// File: rtl/ahb_sram_slave64_if.sv
// AHB-lite bus bundle between the IFU/LSU master mux and the 64-bit SRAM slave.
interface ahb_sram_slave64_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave64.sv
// 64-bit AHB-lite slave fronting a single-port synchronous SRAM with per-byte write mask.
// Optional macro AHB_SRAM_ERR_EN: oversized or misaligned transfers get a two-cycle ERROR.
module ahb_sram_slave64 #(
    parameter int AW_MEM      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_sram_slave64_if.slave bus,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [7:0]        sram_wmask,
    output logic [AW_MEM-1:0] sram_addr,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] WS      = 3'(WAIT_STATES);
    localparam logic [2:0] WS_COLL = (WAIT_STATES >= 7) ? 3'd7 : 3'(WAIT_STATES + 1);

    function automatic logic [2:0] eff_size(input logic [2:0] sz);
        return (sz > 3'd3) ? 3'd3 : sz;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] sz, input logic [2:0] a);
        logic [7:0] m;
        case (sz)
            3'd0:    m = 8'h01 << a;
            3'd1:    m = 8'h03 << {a[2:1], 1'b0};
            3'd2:    m = 8'h0F << {a[2], 2'b00};
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

`ifdef AHB_SRAM_ERR_EN
    function automatic logic misaligned(input logic [2:0] sz, input logic [2:0] a);
        logic r;
        case (sz)
            3'd0:    r = 1'b0;
            3'd1:    r = a[0];
            3'd2:    r = |a[1:0];
            3'd3:    r = |a;
            default: r = 1'b1;
        endcase
        return r;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [2:0]          wait_q, wait_d;
    logic [AW_MEM-1:0]   addr_q, addr_d;
    logic [7:0]          mask_q, mask_d;
    logic                pend_q, pend_d;
    logic                issued_q, issued_d;
    logic [63:0]         rd_hold_q;

    logic addr_ph, accept, bad_xfer, hready_out;
    logic wr_exec, pend_issue, ap_issue;
    logic unused_ok;

    assign addr_ph = bus.HSEL & bus.HTRANS[1];
    assign accept  = addr_ph & bus.HREADY;

`ifdef AHB_SRAM_ERR_EN
    assign bad_xfer = misaligned(bus.HSIZE, bus.HADDR[2:0]);
`else
    assign bad_xfer = 1'b0;
`endif

    always_comb begin
        hready_out = 1'b1;
        case (state_q)
            S_RD, S_WR: hready_out = (wait_q == 3'd0);
            S_ERR1:     hready_out = 1'b0;
            default:    hready_out = 1'b1;
        endcase
    end

    // SRAM port arbitration: write execution, then a collided read, then the address-phase read.
    assign wr_exec    = (state_q == S_WR) && (wait_q == 3'd0);
    assign pend_issue = (state_q == S_RD) && pend_q;
    assign ap_issue   = HRESETn & addr_ph & ~bus.HWRITE & ~bad_xfer & ~wr_exec & ~pend_issue;

    assign sram_cs    = wr_exec | pend_issue | ap_issue;
    assign sram_we    = wr_exec;
    assign sram_wmask = wr_exec ? mask_q : 8'h00;
    assign sram_addr  = (wr_exec | pend_issue) ? addr_q : bus.HADDR[AW_MEM+2:3];
    assign sram_wdata = bus.HWDATA;

    // Only issues that belong to an accepted read may refresh the hold register.
    assign issued_d = (hready_out & accept & ap_issue) | pend_issue;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        pend_d  = pend_q & ~pend_issue;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (hready_out) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            if (accept) begin
                addr_d = bus.HADDR[AW_MEM+2:3];
                mask_d = lane_mask(eff_size(bus.HSIZE), bus.HADDR[2:0]);
                wait_d = 3'd0;
                if (bad_xfer) begin
                    state_d = S_ERR1;
                end else if (bus.HWRITE) begin
                    state_d = S_WR;
                    wait_d  = WS;
                end else begin
                    state_d = S_RD;
                    pend_d  = ~ap_issue;
                    wait_d  = ap_issue ? WS : WS_COLL;
                end
            end
        end else if (wait_q != 3'd0) begin
            wait_d = wait_q - 3'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            wait_q    <= 3'd0;
            addr_q    <= '0;
            mask_q    <= 8'h00;
            pend_q    <= 1'b0;
            issued_q  <= 1'b0;
            rd_hold_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            issued_q <= issued_d;
            if (issued_q) begin
                rd_hold_q <= sram_rdata;
            end
        end
    end

    assign bus.HREADYOUT = hready_out;
    assign bus.HRDATA    = issued_q ? sram_rdata : rd_hold_q;

`ifdef AHB_SRAM_ERR_EN
    assign bus.HRESP = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
    assign bus.HRESP = 1'b0;
`endif

    assign unused_ok = ^{bus.HTRANS[0], bus.HADDR[31:AW_MEM+3]};

endmodule

// File: tb/tb_ahb_sram_slave64.sv
// Scoreboard bench for ahb_sram_slave64: a zero-wait and a two-wait-state instance, memory reference model.
module tb_ahb_sram_slave64;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic        hready_ext;
    logic        sel;

    ahb_sram_slave64_if b0();
    ahb_sram_slave64_if b2();

    assign b0.HSEL = hsel & ~sel;   assign b2.HSEL = hsel & sel;
    assign b0.HADDR = haddr;        assign b2.HADDR = haddr;
    assign b0.HTRANS = htrans;      assign b2.HTRANS = htrans;
    assign b0.HWRITE = hwrite;      assign b2.HWRITE = hwrite;
    assign b0.HSIZE = hsize;        assign b2.HSIZE = hsize;
    assign b0.HWDATA = hwdata;      assign b2.HWDATA = hwdata;
    assign b0.HREADY = b0.HREADYOUT & hready_ext;
    assign b2.HREADY = b2.HREADYOUT & hready_ext;

    logic s0_cs, s0_we, s2_cs, s2_we;
    logic [7:0] s0_mask, s2_mask;
    logic [AW-1:0] s0_addr, s2_addr;
    logic [63:0] s0_wdata, s2_wdata, s0_rdata, s2_rdata;

    ahb_sram_slave64 #(.AW_MEM(AW), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(rstn), .bus(b0.slave),
        .sram_cs(s0_cs), .sram_we(s0_we), .sram_wmask(s0_mask), .sram_addr(s0_addr),
        .sram_wdata(s0_wdata), .sram_rdata(s0_rdata));

    ahb_sram_slave64 #(.AW_MEM(AW), .WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESETn(rstn), .bus(b2.slave),
        .sram_cs(s2_cs), .sram_we(s2_we), .sram_wmask(s2_mask), .sram_addr(s2_addr),
        .sram_wdata(s2_wdata), .sram_rdata(s2_rdata));

    // SRAM macro models
    logic [63:0] ram0 [1024];
    logic [63:0] ram2 [1024];
    always @(posedge clk) begin
        if (s0_cs) begin
            if (s0_we) begin
                for (int i = 0; i < 8; i++) if (s0_mask[i]) ram0[s0_addr][8*i +: 8] <= s0_wdata[8*i +: 8];
            end else s0_rdata <= ram0[s0_addr];
        end
        if (s2_cs) begin
            if (s2_we) begin
                for (int i = 0; i < 8; i++) if (s2_mask[i]) ram2[s2_addr][8*i +: 8] <= s2_wdata[8*i +: 8];
            end else s2_rdata <= ram2[s2_addr];
        end
    end

    // Reference memory, updated when a transfer is accepted
    logic [63:0] ref0 [1024];
    logic [63:0] ref2 [1024];

    typedef struct {
        bit          wr;
        bit          err;
        logic [63:0] data;
        int          stalls;
        logic [7:0]  mask;
        int          widx;
    } exp_t;
    exp_t expq[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  dp_active = 1'b0;
    bit  prev_wr = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endfunction

    wire        cur_rdy   = sel ? b2.HREADYOUT : b0.HREADYOUT;
    wire        cur_hrdy  = sel ? b2.HREADY : b0.HREADY;
    wire        cur_resp  = sel ? b2.HRESP : b0.HRESP;
    wire [63:0] cur_rdata = sel ? b2.HRDATA : b0.HRDATA;
    wire        cur_cs    = sel ? s2_cs : s0_cs;
    wire        cur_we    = sel ? s2_we : s0_we;
    wire [7:0]  cur_mask  = sel ? s2_mask : s0_mask;
    wire [AW-1:0] cur_addr = sel ? s2_addr : s0_addr;

    function automatic logic [7:0] model_mask(input logic [2:0] sz, input logic [31:0] a);
        logic [7:0] m;
        int n, base;
        m = 8'h00;
        n = 1 << ((sz > 3) ? 3 : sz);
        base = (int'(a % 8) / n) * n;
        for (int i = 0; i < n; i++) m[base + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_rd(input int idx);
        return sel ? ref2[idx] : ref0[idx];
    endfunction

    function automatic void ref_wr(input int idx, input logic [7:0] m, input logic [63:0] d);
        logic [63:0] w;
        w = ref_rd(idx);
        for (int i = 0; i < 8; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        if (sel) ref2[idx] = w; else ref0[idx] = w;
    endfunction

    // Monitor: follows data phases on the bus and pops the scoreboard on completion
    initial begin
        exp_t e;
        int   stalls;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rstn) begin
                if (dp_active) begin
                    if (!cur_rdy) begin
                        stalls++;
                        if (expq.size() > 0 && expq[0].wr) chk("wr_stall_no_we", cur_we, 1'b0);
                    end else begin
                        if (expq.size() == 0) chk("scoreboard_empty", 1, 0);
                        else begin
                            e = expq.pop_front();
                            chk("stall_cycles", stalls, e.stalls);
                            chk("hresp", cur_resp, e.err);
                            if (e.err) chk("err_no_cs", cur_cs, 1'b0);
                            else if (e.wr) begin
                                chk("wr_we", cur_we, 1'b1);
                                chk("wr_mask", cur_mask, e.mask);
                                chk("wr_addr", cur_addr, e.widx);
                            end else chk("rd_data", cur_rdata, e.data);
                        end
                        dp_active = 1'b0;
                    end
                end
                if (cur_hrdy && hsel && htrans[1]) begin
                    dp_active = 1'b1;
                    stalls = 0;
                end
            end
        end
    end

    task automatic drive_addr(input bit en, input bit w, input logic [31:0] a, input logic [2:0] sz);
        hsel   = en ? 1'b1 : 1'($urandom_range(0, 1));
        htrans = en ? ($urandom_range(0, 1) ? 2'b10 : 2'b11) : ($urandom_range(0, 1) ? 2'b00 : 2'b01);
        hwrite = w;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic wait_accept();
        bit r;
        int n;
        r = 1'b0;
        n = 0;
        while (!r && n < 64) begin
            @(negedge clk);
            r = cur_hrdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) chk("accept_timeout", 0, 1);
    endtask

    task automatic post(input bit en, input bit w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] wd);
        exp_t e;
        bit   err;
        hwdata = wd;
        if (!en) begin
            prev_wr = 1'b0;
            return;
        end
        err = 1'b0;
`ifdef AHB_SRAM_ERR_EN
        if (sz > 3 || (a % (32'd1 << sz)) != 0) err = 1'b1;
`endif
        e.wr = w; e.err = err; e.widx = int'(a[AW+2:3]); e.mask = 8'h00; e.data = 64'd0;
        if (err) e.stalls = 1;
        else if (w) begin
            e.mask = model_mask(sz, a);
            e.stalls = sel ? 2 : 0;
            ref_wr(e.widx, e.mask, wd);
        end else begin
            e.data = ref_rd(e.widx);
            e.stalls = (sel ? 2 : 0) + (prev_wr ? 1 : 0);
        end
        prev_wr = w && !err;
        expq.push_back(e);
    endtask

    task automatic xfer(input bit en, input bit w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] wd);
        drive_addr(en, w, a, sz);
        wait_accept();
        post(en, w, a, sz, wd);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            xfer(0, 0, 32'd0, 3'd0, 64'd0);
            n++;
        end
        xfer(0, 0, 32'd0, 3'd0, 64'd0);
        chk("drain_empty", expq.size(), 0);
    endtask

    task automatic random_traffic(input int n);
        bit en, w;
        logic [2:0] sz;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            en = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            a  = {$urandom} & 32'hFFFF_E000;
            a  = a | (32'($urandom_range(0, 15)) << 3);
`ifdef AHB_SRAM_ERR_EN
            a  = a | (32'($urandom_range(0, 7)) & ~((32'd1 << sz) - 1));
`else
            a  = a | 32'($urandom_range(0, 7));
`endif
            xfer(en, w, a, sz, {$urandom, $urandom});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram0[i] = {32'hC0DE_0000 | i, ~i};
            ram2[i] = {32'hBEEF_0000 | i, i};
            ref0[i] = ram0[i];
            ref2[i] = ram2[i];
        end
        rstn = 1'b0; sel = 1'b0; hready_ext = 1'b1; hwdata = 64'd0;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h10; hsize = 3'd3;

        // Reset state, with a read address phase presented while in reset
        repeat (2) @(negedge clk);
        chk("rst_ready0", b0.HREADYOUT, 1'b1);
        chk("rst_ready2", b2.HREADYOUT, 1'b1);
        chk("rst_resp0", b0.HRESP, 1'b0);
        chk("rst_cs0", s0_cs, 1'b0);
        chk("rst_cs2", s2_cs, 1'b0);
        chk("rst_we0", s0_we, 1'b0);
        chk("rst_mask0", s0_mask, 8'h00);
        hsel = 1'b0; htrans = 2'b00;
        rstn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Zero-wait instance: write then back-to-back read of the same dword
        xfer(1, 1, 32'h10, 3'd3, 64'h0123_4567_89AB_CDEF);
        xfer(1, 0, 32'h10, 3'd3, 64'd0);
        xfer(0, 0, 32'd0, 3'd0, 64'd0);
        // Byte write to lane 3, idle, dword read
        xfer(1, 1, 32'h13, 3'd0, 64'h1111_1111_AA22_2222);
        xfer(0, 0, 32'd0, 3'd0, 64'd0);
        xfer(1, 0, 32'h10, 3'd3, 64'd0);
        drain();

        // Selected IDLE, then a read held off by HREADY low
        hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h40; hsize = 3'd3;
        wait_accept();
        post(0, 0, 32'd0, 3'd0, 64'd0);
        @(negedge clk);
        chk("idle_sel_ready", b0.HREADYOUT, 1'b1);
        chk("idle_sel_cs", s0_cs, 1'b0);
        @(posedge clk); #1;
        hready_ext = 1'b0; htrans = 2'b10; haddr = 32'h48;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_cs", s0_cs, 1'b1);
            chk("hold_we", s0_we, 1'b0);
            chk("hold_ready", b0.HREADYOUT, 1'b1);
            chk("hold_addr", s0_addr, 10'd9);
            @(posedge clk); #1;
        end
        hready_ext = 1'b1;
        wait_accept();
        post(1, 0, 32'h48, 3'd3, 64'd0);
        drain();

`ifdef AHB_SRAM_ERR_EN
        // Misaligned word read: ERROR response, no SRAM access
        drive_addr(1, 0, 32'h06, 3'd2);
        @(negedge clk);
        chk("err_addr_no_cs", s0_cs, 1'b0);
        @(posedge clk); #1;
        post(1, 0, 32'h06, 3'd2, 64'd0);
        xfer(1, 0, 32'h08, 3'd3, 64'd0);
`else
        // Misaligned word read is aligned down; oversized write treated as dword
        xfer(1, 0, 32'h06, 3'd2, 64'd0);
        xfer(1, 1, 32'h18, 3'd5, 64'hFEDC_BA98_7654_3210);
        xfer(1, 0, 32'h18, 3'd3, 64'd0);
`endif
        drain();

        random_traffic(150);
        drain();

        // Two-wait-state instance
        sel = 1'b1;
        prev_wr = 1'b0;
        xfer(1, 0, 32'h20, 3'd3, 64'd0);
        xfer(1, 1, 32'h20, 3'd2, 64'h5A5A_5A5A_1357_9BDF);
        xfer(0, 0, 32'd0, 3'd0, 64'd0);
        xfer(1, 0, 32'h20, 3'd3, 64'd0);
        xfer(1, 1, 32'h28, 3'd1, 64'h0000_BEEF_0000_0000);
        xfer(1, 0, 32'h28, 3'd3, 64'd0);
        drain();
        random_traffic(80);
        drain();

        // Reset pulsed during a write stall cycle
        mon_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd3;
        wait_accept();
        hwdata = 64'hDEAD_BEEF_DEAD_BEEF;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        chk("rst_mid_stall", b2.HREADYOUT, 1'b0);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_ready", b2.HREADYOUT, 1'b1);
        chk("rst_mid_we", s2_we, 1'b0);
        @(negedge clk);
        chk("rst_hold_we", s2_we, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_after_ready", b2.HREADYOUT, 1'b1);
        chk("rst_after_we", s2_we, 1'b0);
        @(posedge clk); #1;
        dp_active = 1'b0;
        prev_wr = 1'b0;
        mon_en = 1'b1;
        xfer(1, 0, 32'h30, 3'd3, 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
